// File: rtl/mcycle_ctrl_if.sv
// Bus between the multi-cycle sequencer and the decoder/datapath: class flags in, strobes out.
// The sequencer takes the master modport; the datapath side takes slave.
interface mcycle_ctrl_if;
    logic       cls_br;
    logic       cls_load;
    logic       cls_store;
    logic       br_taken;
    logic [2:0] state;
    logic       inst_req;
    logic       ir_we;
    logic       data_req;
    logic       data_we;
    logic       rf_we;
    logic       pc_we;
    logic       pc_sel_br;
    logic       commit;

    modport master (
        input  cls_br, cls_load, cls_store, br_taken,
        output state, inst_req, ir_we, data_req, data_we, rf_we, pc_we, pc_sel_br, commit
    );

    modport slave (
        output cls_br, cls_load, cls_store, br_taken,
        input  state, inst_req, ir_we, data_req, data_we, rf_we, pc_we, pc_sel_br, commit
    );
endinterface

// File: rtl/mcycle_ctrl.sv
// IF->ID->EXE->MEM->WB sequencer for the multi-cycle LA32R core; one instruction in flight.
// Optional MCYC_PERF_CNT_EN adds perf_cycle / perf_instret counters.
module mcycle_ctrl #(
    parameter int IMEM_LAT = 1,
    parameter int DMEM_LAT = 1
) (
    input  logic              clk,
    input  logic              resetn,
    mcycle_ctrl_if.master     bus
`ifdef MCYC_PERF_CNT_EN
    ,
    output logic [31:0]       perf_cycle,
    output logic [31:0]       perf_instret
`endif
);

    localparam int MAX_LAT = (IMEM_LAT > DMEM_LAT) ? IMEM_LAT : DMEM_LAT;
    localparam int CW      = $clog2(MAX_LAT + 1) + 1;
    localparam logic [CW-1:0] IF_LAST  = CW'(IMEM_LAT);
    localparam logic [CW-1:0] MEM_LAST = CW'(DMEM_LAT);

    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EXE = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    // run_q holds off the first IF until the first edge after reset release.
    logic          run_q;

    logic inst_req_c, ir_we_c, data_req_c, data_we_c, rf_we_c, pc_we_c, commit_c;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IF;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else if (!run_q) begin
            run_q <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= (state_d != state_q) ? '0 : cnt_q + CW'(1);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d    = state_q;
        inst_req_c = 1'b0;
        ir_we_c    = 1'b0;
        data_req_c = 1'b0;
        data_we_c  = 1'b0;
        rf_we_c    = 1'b0;
        pc_we_c    = 1'b0;
        commit_c   = 1'b0;
        case (state_q)
            S_IF: begin
                inst_req_c = 1'b1;
                if (cnt_q == IF_LAST) begin
                    ir_we_c = 1'b1;
                    state_d = S_ID;
                end
            end
            S_ID: begin
                if (bus.cls_br) begin
                    pc_we_c  = 1'b1;
                    commit_c = 1'b1;
                    state_d  = S_IF;
                end else begin
                    state_d = S_EXE;
                end
            end
            S_EXE: begin
                state_d = (bus.cls_load || bus.cls_store) ? S_MEM : S_WB;
            end
            S_MEM: begin
                data_req_c = 1'b1;
                if (bus.cls_store) begin
                    data_we_c = 1'b1;
                    pc_we_c   = 1'b1;
                    commit_c  = 1'b1;
                    state_d   = S_IF;
                end else if (cnt_q == MEM_LAST) begin
                    state_d = S_WB;
                end
            end
            S_WB: begin
                rf_we_c  = 1'b1;
                pc_we_c  = 1'b1;
                commit_c = 1'b1;
                state_d  = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    // Gating with run_q forces every strobe low the instant reset asserts.
    assign bus.state     = state_q;
    assign bus.inst_req  = run_q & inst_req_c;
    assign bus.ir_we     = run_q & ir_we_c;
    assign bus.data_req  = run_q & data_req_c;
    assign bus.data_we   = run_q & data_we_c;
    assign bus.rf_we     = run_q & rf_we_c;
    assign bus.pc_we     = run_q & pc_we_c;
    assign bus.commit    = run_q & commit_c;
    assign bus.pc_sel_br = run_q & pc_we_c & bus.br_taken;

`ifdef MCYC_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_cycle   <= '0;
            perf_instret <= '0;
        end else if (run_q) begin
            perf_cycle <= perf_cycle + 32'd1;
            if (commit_c) perf_instret <= perf_instret + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mcycle_ctrl.sv
// Self-checking bench for mcycle_ctrl: cycle-count table, corner sequences and a random
// instruction stream compared against a per-instruction trace model.
module tb_mcycle_ctrl;
    localparam int IMEM_LAT = 1;
    localparam int DMEM_LAT = 3;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    mcycle_ctrl_if bus();
`ifdef MCYC_PERF_CNT_EN
    logic [31:0] perf_cycle, perf_instret;
`endif

    mcycle_ctrl #(.IMEM_LAT(IMEM_LAT), .DMEM_LAT(DMEM_LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
`ifdef MCYC_PERF_CNT_EN
        ,
        .perf_cycle   (perf_cycle),
        .perf_instret (perf_instret)
`endif
    );

    typedef enum int {C_ALU, C_BR, C_LD, C_ST} cls_e;

    typedef struct packed {
        logic [2:0] st;
        logic ireq, irwe, dreq, dwe, rfwe, pcwe, psel, cmt;
    } obs_t;

    typedef struct {
        cls_e cls;
        logic taken;
        int   cycles;
        logic psel;
        int   rf_cnt;
        int   dwe_cnt;
    } vec_t;

    int   n_checks = 0;
    int   n_fail   = 0;
    obs_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic obs_t sample();
        obs_t o;
        o.st   = bus.state;
        o.ireq = bus.inst_req;
        o.irwe = bus.ir_we;
        o.dreq = bus.data_req;
        o.dwe  = bus.data_we;
        o.rfwe = bus.rf_we;
        o.pcwe = bus.pc_we;
        o.psel = bus.pc_sel_br;
        o.cmt  = bus.commit;
        return o;
    endfunction

    task automatic set_cls(input cls_e c, input logic tk);
        bus.cls_br    = (c == C_BR);
        bus.cls_load  = (c == C_LD);
        bus.cls_store = (c == C_ST);
        bus.br_taken  = tk;
    endtask

    // Expected per-cycle outputs of one instruction, derived from its class alone.
    task automatic model_instr(input cls_e c, input logic tk);
        obs_t o;
        for (int i = 0; i <= IMEM_LAT; i++) begin
            o = '0; o.st = 3'd0; o.ireq = 1'b1; o.irwe = (i == IMEM_LAT);
            exp_q.push_back(o);
        end
        o = '0; o.st = 3'd1;
        if (c == C_BR) begin
            o.pcwe = 1'b1; o.cmt = 1'b1; o.psel = tk;
            exp_q.push_back(o);
            return;
        end
        exp_q.push_back(o);
        o = '0; o.st = 3'd2;
        exp_q.push_back(o);
        if (c == C_ST) begin
            o = '0; o.st = 3'd3; o.dreq = 1'b1; o.dwe = 1'b1;
            o.pcwe = 1'b1; o.cmt = 1'b1; o.psel = tk;
            exp_q.push_back(o);
            return;
        end
        if (c == C_LD) begin
            for (int i = 0; i <= DMEM_LAT; i++) begin
                o = '0; o.st = 3'd3; o.dreq = 1'b1;
                exp_q.push_back(o);
            end
        end
        o = '0; o.st = 3'd4; o.rfwe = 1'b1; o.pcwe = 1'b1; o.cmt = 1'b1; o.psel = tk;
        exp_q.push_back(o);
    endtask

    // Entered at a falling edge with the DUT at the start of IF; returns the same way.
    task automatic run_model(input cls_e c, input logic tk, input string name);
        obs_t e;
        set_cls(c, tk);
        exp_q.delete();
        model_instr(c, tk);
        while (exp_q.size() > 0) begin
            #1;
            e = exp_q.pop_front();
            check(name, 32'(sample()), 32'(e));
            @(negedge clk);
        end
    endtask

    task automatic run_counted(input vec_t v, input int idx);
        int   cyc = 0, rf = 0, dw = 0, both = 0;
        logic done = 1'b0;
        logic psel = 1'b0;
        set_cls(v.cls, v.taken);
        while (!done && cyc < 50) begin
            #1;
            cyc++;
            rf   += int'(bus.rf_we);
            dw   += int'(bus.data_we);
            both += int'(bus.rf_we & bus.data_we);
            if (bus.commit) begin
                done = 1'b1;
                psel = bus.pc_sel_br;
            end
            @(negedge clk);
        end
        check($sformatf("tbl%0d_cycles", idx), 32'(cyc), 32'(v.cycles));
        check($sformatf("tbl%0d_pc_sel_br", idx), 32'(psel), 32'(v.psel));
        check($sformatf("tbl%0d_rf_we_cnt", idx), 32'(rf), 32'(v.rf_cnt));
        check($sformatf("tbl%0d_data_we_cnt", idx), 32'(dw), 32'(v.dwe_cnt));
        check($sformatf("tbl%0d_rf_dwe_overlap", idx), 32'(both), 32'd0);
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        set_cls(C_ALU, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        check("reset_outputs", 32'(sample()), 32'd0);
        resetn = 1'b1;
        #1;
        check("reset_release_idle", 32'(sample()), 32'd0);
        @(negedge clk);
    endtask

    vec_t tbl[7];
    int   add_states[5];

    initial begin
        tbl[0] = '{C_ALU, 1'b0, 5, 1'b0, 1, 0};
        tbl[1] = '{C_BR,  1'b1, 3, 1'b1, 0, 0};
        tbl[2] = '{C_BR,  1'b0, 3, 1'b0, 0, 0};
        tbl[3] = '{C_ST,  1'b0, 5, 1'b0, 0, 1};
        tbl[4] = '{C_LD,  1'b0, 9, 1'b0, 1, 0};
        tbl[5] = '{C_ST,  1'b0, 5, 1'b0, 0, 1};
        tbl[6] = '{C_LD,  1'b0, 9, 1'b0, 1, 0};
        add_states = '{0, 0, 1, 2, 4};

        do_reset();

        for (int i = 0; i < 7; i++) run_counted(tbl[i], i);

        // add.w: state sequence, and commit-side strobes only in WB.
        set_cls(C_ALU, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check($sformatf("add_state%0d", i), 32'(bus.state), 32'(add_states[i]));
            check($sformatf("add_commit%0d", i), 32'(bus.commit), 32'(i == 4));
            check($sformatf("add_psel%0d", i), 32'(bus.pc_sel_br), 32'd0);
            @(negedge clk);
        end

        // taken branch then store and load, full per-cycle traces
        run_model(C_BR, 1'b1, "beq_taken");
        run_model(C_ST, 1'b0, "st_w");
        run_model(C_LD, 1'b0, "ld_w");

        // reset asserted in the middle of a load's MEM phase
        set_cls(C_LD, 1'b0);
        repeat (4) @(negedge clk);
        repeat (2) @(negedge clk);
        #1;
        check("midload_in_mem", 32'(bus.state), 32'd3);
        check("midload_dreq", 32'(bus.data_req), 32'd1);
        #1 resetn = 1'b0;
        #1;
        check("midload_reset_outputs", 32'(sample()), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
        #1;
        check("midload_release_idle", 32'(sample()), 32'd0);
        @(negedge clk);
        run_model(C_ALU, 1'b0, "after_reset_alu");

        // random instruction stream
        for (int n = 0; n < 40; n++) begin
            cls_e c;
            c = cls_e'($urandom_range(0, 3));
            run_model(c, 1'($urandom_range(0, 1)), $sformatf("rand%0d", n));
        end

`ifdef MCYC_PERF_CNT_EN
        do_reset();
        check("perf_cycle_zero", perf_cycle, 32'd0);
        for (int n = 0; n < 10; n++) run_model(C_ALU, 1'b0, $sformatf("perf_add%0d", n));
        check("perf_instret", perf_instret, 32'd10);
        check("perf_cycle", perf_cycle, 32'd50);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
